// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x-oversampling UART receiver with a valid/ready byte output.
// Contains its own tick generator, a two-flop input synchronizer, a
// three-sample majority vote per bit, and framing/overrun detection.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> frame is start + 8 data + parity + stop; parity_err is active
//   undefined -> frame is 8N1; the parity state is not built and parity_err is 0
module uart_rx_os #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic [1:0] baud_select,
    input  logic       parity_sel,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun_err
);

    // Divisors are truncated, so the bit period is 16*DIV clocks exactly.
    localparam logic [15:0] DIV_9600  = 16'(CLK_FREQ / (9600  * OVERSAMPLE));
    localparam logic [15:0] DIV_19200 = 16'(CLK_FREQ / (19200 * OVERSAMPLE));
    localparam logic [15:0] DIV_38400 = 16'(CLK_FREQ / (38400 * OVERSAMPLE));
    localparam logic [15:0] DIV_57600 = 16'(CLK_FREQ / (57600 * OVERSAMPLE));

    // Sample positions inside a bit (tick index 0..15).
    localparam logic [3:0] SAMP_A    = 4'd7;
    localparam logic [3:0] SAMP_B    = 4'd8;
    localparam logic [3:0] SAMP_C    = 4'd9;
    localparam logic [3:0] SAMP_LAST = 4'd15;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;
`endif

    state_t      state;

    logic        rx_m;
    logic        rx_s;
    logic        rx_prev;

    logic [15:0] div;
    logic [15:0] div_sel;
    logic [15:0] tick_cnt;
    logic        tick;

    logic [3:0]  samp_cnt;
    logic [2:0]  bit_idx;
    logic        samp_a;
    logic        samp_b;
    logic        vote;
    logic [7:0]  shift_reg;
    logic        start_edge;

`ifdef UART_RX_PARITY_EN
    logic        par_bad;
    logic        par_err_r;
    assign parity_err = par_err_r;
`else
    logic        unused_parity_sel;
    assign unused_parity_sel = parity_sel;
    assign parity_err        = 1'b0;
`endif

    // Two-of-three vote over the samples taken at ticks 7, 8 and 9.
    function automatic logic majority(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign vote       = majority(samp_a, samp_b, rx_s);
    assign tick       = (tick_cnt >= (div - 16'd1));
    assign start_edge = (state == IDLE) && rx_prev && !rx_s;

    // Divisor lookup for the requested baud rate.
    always_comb begin
        div_sel = DIV_9600;
        case (baud_select)
            2'b00:   div_sel = DIV_9600;
            2'b01:   div_sel = DIV_19200;
            2'b10:   div_sel = DIV_38400;
            default: div_sel = DIV_57600;
        endcase
    end

    // Two-flop synchronizer plus one more flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_m    <= rx;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
        end
    end

    // 16x tick generator; restarted on the start edge so ticks align to it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div      <= DIV_9600;
            tick_cnt <= 16'd0;
        end else begin
            // Baud changes only take effect between frames.
            if (state == IDLE) begin
                div <= div_sel;
            end
            if (start_edge || tick) begin
                tick_cnt <= 16'd0;
            end else begin
                tick_cnt <= tick_cnt + 16'd1;
            end
        end
    end

    // Receive FSM with registered byte, handshake and error-pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            samp_cnt    <= 4'd0;
            bit_idx     <= 3'd0;
            samp_a      <= 1'b0;
            samp_b      <= 1'b0;
            shift_reg   <= 8'h00;
            data        <= 8'h00;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad     <= 1'b0;
            par_err_r   <= 1'b0;
`endif
        end else begin
            // Error outputs are single-cycle pulses.
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_r   <= 1'b0;
`endif
            // Consumer accept; a same-cycle load further down overrides this.
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            // The first two vote samples are captured in every bit-timed state.
            if (tick && (state != IDLE) && (state != WAIT_HIGH)) begin
                samp_cnt <= samp_cnt + 4'd1;
                if (samp_cnt == SAMP_A) begin
                    samp_a <= rx_s;
                end
                if (samp_cnt == SAMP_B) begin
                    samp_b <= rx_s;
                end
            end

            case (state)
                IDLE: begin
                    if (start_edge) begin
                        samp_cnt <= 4'd0;
                        bit_idx  <= 3'd0;
                        state    <= START;
                    end
                end

                START: begin
                    if (tick) begin
                        // A line already back high at mid-bit is a glitch.
                        if ((samp_cnt == SAMP_A) && rx_s) begin
                            state <= IDLE;
                        end else if (samp_cnt == SAMP_LAST) begin
                            state <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (samp_cnt == SAMP_C) begin
                            shift_reg <= {vote, shift_reg[7:1]};
                        end
                        if (samp_cnt == SAMP_LAST) begin
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (samp_cnt == SAMP_C) begin
                            par_bad <= (vote != ((^shift_reg) ^ parity_sel));
                        end
                        if (samp_cnt == SAMP_LAST) begin
                            state <= STOP;
                        end
                    end
                end
`endif

                STOP: begin
                    // Resolve mid-bit so a start edge right after it is caught.
                    if (tick && (samp_cnt == SAMP_C)) begin
                        if (!vote) begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                        end else if (par_bad) begin
                            par_err_r <= 1'b1;
                            state     <= IDLE;
`endif
                        end else if (data_valid && !data_ready) begin
                            overrun_err <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            data       <= shift_reg;
                            data_valid <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end

                WAIT_HIGH: begin
                    // Break or stuck-low line: wait for idle level before rearming.
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Testbench for uart_rx_os: table of frames plus hand-written corner cases,
// with a scoreboard queue of expected bytes checked at each handshake.
module tb_uart_rx_os;

    // 1.8432 MHz gives divisors 12/6/3/2, i.e. bit periods 192/96/48/32 clk.
    localparam int TB_CLK = 1_843_200;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [1:0] baud_select;
    logic       parity_sel;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       parity_err;
    logic       overrun_err;

    int checks = 0;
    int errors = 0;
    int n_deliv = 0;
    int n_ferr = 0;
    int n_perr = 0;
    int n_ovr = 0;
    int n_vld = 0;

    logic [7:0] exp_q[$];

    uart_rx_os #(
        .CLK_FREQ   (TB_CLK),
        .OVERSAMPLE (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .baud_select (baud_select),
        .parity_sel  (parity_sel),
        .data        (data),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun_err (overrun_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] baud;
        logic [7:0] byte_v;
        logic       stop;
        int         exp_deliver;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    function automatic int bit_clks(input logic [1:0] s);
        case (s)
            2'b00:   return 192;
            2'b01:   return 96;
            2'b10:   return 48;
            default: return 32;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one frame; must be called right after a negedge.
    task automatic send_frame(input logic [1:0] bsel, input logic [7:0] b, input logic stop,
                              input logic has_par, input logic pbit);
        int bp;
        bp = bit_clks(bsel);
        rx = 1'b0;
        repeat (bp) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (bp) @(negedge clk);
        end
        if (has_par) begin
            rx = pbit;
            repeat (bp) @(negedge clk);
        end
        rx = stop;
        repeat (bp) @(negedge clk);
    endtask

    // Scoreboard and event counters, sampled between driver updates and the next posedge.
    always @(negedge clk) begin
        #1;
        if (data_valid) n_vld++;
        if (frame_err) n_ferr++;
        if (parity_err) n_perr++;
        if (overrun_err) n_ovr++;
        if (data_valid && data_ready) begin
            n_deliv++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte: got %0h expected none", data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (data !== e) begin
                    errors++;
                    $display("FAIL byte_value: got %0h expected %0h", data, e);
                end
            end
        end
    end

    initial begin
        int d0, f0, v0, p0, o0, bp;
        logic pb;

        vecs[0] = '{2'b00, 8'h4D, 1'b1, 1, 0};
        vecs[1] = '{2'b01, 8'h00, 1'b1, 1, 0};
        vecs[2] = '{2'b10, 8'hFF, 1'b1, 1, 0};
        vecs[3] = '{2'b11, 8'h80, 1'b1, 1, 0};
        vecs[4] = '{2'b00, 8'h33, 1'b0, 0, 1};
        vecs[5] = '{2'b01, 8'hA5, 1'b1, 1, 0};

        rst_n = 1'b0;
        rx = 1'b1;
        baud_select = 2'b00;
        parity_sel = 1'b0;
        data_ready = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("reset_data", {24'd0, data}, 32'h00);
        check("reset_valid", {31'd0, data_valid}, 32'd0);
        check("reset_errs", {29'd0, frame_err, parity_err, overrun_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Table-driven frames with the consumer always ready.
        for (int k = 0; k < 6; k++) begin
            baud_select = vecs[k].baud;
            bp = bit_clks(vecs[k].baud);
            @(negedge clk);
            d0 = n_deliv; f0 = n_ferr; v0 = n_vld; o0 = n_ovr; p0 = n_perr;
            if (vecs[k].exp_deliver != 0) exp_q.push_back(vecs[k].byte_v);
            pb = (^vecs[k].byte_v) ^ parity_sel;
            send_frame(vecs[k].baud, vecs[k].byte_v, vecs[k].stop, PAR_EN, pb);
            rx = 1'b1;
            repeat (2 * bp) @(negedge clk);
            check($sformatf("vec%0d_deliver", k), n_deliv - d0, vecs[k].exp_deliver);
            check($sformatf("vec%0d_valid_cycles", k), n_vld - v0, vecs[k].exp_deliver);
            check($sformatf("vec%0d_frame_err", k), n_ferr - f0, vecs[k].exp_ferr);
            check($sformatf("vec%0d_other_errs", k), (n_ovr - o0) + (n_perr - p0), 0);
            if (vecs[k].exp_deliver != 0)
                check($sformatf("vec%0d_data_reg", k), {24'd0, data}, {24'd0, vecs[k].byte_v});
        end

        // False start: line low well under half a bit, then a real frame.
        baud_select = 2'b00;
        @(negedge clk);
        d0 = n_deliv; f0 = n_ferr;
        rx = 1'b0;
        repeat (60) @(negedge clk);
        rx = 1'b1;
        repeat (400) @(negedge clk);
        check("false_start_quiet", (n_deliv - d0) + (n_ferr - f0), 0);
        exp_q.push_back(8'hA5);
        send_frame(2'b00, 8'hA5, 1'b1, PAR_EN, (^8'hA5) ^ parity_sel);
        repeat (384) @(negedge clk);
        check("after_false_start", n_deliv - d0, 1);

        // Framing error followed by a long low line, then recovery.
        d0 = n_deliv; f0 = n_ferr;
        send_frame(2'b00, 8'h33, 1'b0, PAR_EN, (^8'h33) ^ parity_sel);
        repeat (800) @(negedge clk);
        check("frame_err_once", n_ferr - f0, 1);
        check("frame_err_no_data", n_deliv - d0, 0);
        check("frame_err_valid_low", {31'd0, data_valid}, 32'd0);
        rx = 1'b1;
        repeat (400) @(negedge clk);
        exp_q.push_back(8'h5A);
        send_frame(2'b00, 8'h5A, 1'b1, PAR_EN, (^8'h5A) ^ parity_sel);
        repeat (384) @(negedge clk);
        check("after_frame_err", n_deliv - d0, 1);

`ifdef UART_RX_PARITY_EN
        // Odd parity: correct parity bit accepted, wrong one flagged.
        parity_sel = 1'b1;
        d0 = n_deliv; p0 = n_perr;
        exp_q.push_back(8'h4D);
        send_frame(2'b00, 8'h4D, 1'b1, 1'b1, 1'b1);
        repeat (384) @(negedge clk);
        check("odd_parity_ok", n_deliv - d0, 1);
        send_frame(2'b00, 8'h4D, 1'b1, 1'b1, 1'b0);
        repeat (384) @(negedge clk);
        check("parity_err_pulse", n_perr - p0, 1);
        check("parity_err_no_data", n_deliv - d0, 1);
        parity_sel = 1'b0;
`endif

        // Overrun: consumer stalled across two back-to-back frames.
        baud_select = 2'b01;
        data_ready = 1'b0;
        @(negedge clk);
        o0 = n_ovr; d0 = n_deliv;
        exp_q.push_back(8'h11);
        send_frame(2'b01, 8'h11, 1'b1, PAR_EN, (^8'h11) ^ parity_sel);
        send_frame(2'b01, 8'h22, 1'b1, PAR_EN, (^8'h22) ^ parity_sel);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        check("overrun_pulse", n_ovr - o0, 1);
        check("overrun_keeps_old", {24'd0, data}, 32'h11);
        check("overrun_valid_held", {31'd0, data_valid}, 32'd1);
        data_ready = 1'b1;
        @(negedge clk);
        #2;
        check("accept_clears_valid", {31'd0, data_valid}, 32'd0);
        check("overrun_delivered_once", n_deliv - d0, 1);

        // Reset in the middle of data bit 4 at 57600, then a clean frame.
        baud_select = 2'b11;
        @(negedge clk);
        d0 = n_deliv;
        fork
            send_frame(2'b11, 8'hFF, 1'b1, PAR_EN, (^8'hFF) ^ parity_sel);
            begin
                repeat (176) @(negedge clk);
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                #1;
                check("midreset_outputs", {19'd0, data, data_valid, frame_err, parity_err, overrun_err}, 32'd0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        rx = 1'b1;
        repeat (100) @(negedge clk);
        check("midreset_no_data", n_deliv - d0, 0);
        exp_q.push_back(8'h81);
        send_frame(2'b11, 8'h81, 1'b1, PAR_EN, (^8'h81) ^ parity_sel);
        repeat (100) @(negedge clk);
        check("after_reset_frame", n_deliv - d0, 1);
        check("after_reset_data_reg", {24'd0, data}, 32'h81);

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
